// File: rtl/lacr_rx.sv
// Receive-side config/idle ordered-set parser: extracts /C1/,/C2/ config words,
// qualifies /I1/,/I2/ idle runs and counts aborted ordered sets, all in rx_clk.
module lacr_rx #(
   parameter int IDLE_COUNT = 3
) (
   input  logic        rx_clk,
   input  logic        rst,
   input  logic        los,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_is_k,
   input  logic        rx_err,
   output logic [15:0] lacr_out,
   output logic        lacr_stb,
   output logic        idle_match,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {HUNT, COMMA, CFG_LO, CFG_HI} state_t;

   state_t      state, state_n;
   logic [7:0]  cfg_lo, cfg_lo_n;
   logic [3:0]  idle_cnt, idle_cnt_n;
   logic [15:0] out_n;
   logic        stb_n;
   logic        err_inc;
   logic        is_comma;
   logic        is_cfg_id;
   logic        is_idle_id;

   assign is_comma   = rx_is_k && (rx_data == 8'hBC);
   assign is_cfg_id  = !rx_is_k && ((rx_data == 8'hB5) || (rx_data == 8'h42));
   assign is_idle_id = !rx_is_k && ((rx_data == 8'hC5) || (rx_data == 8'h50));

   // los overrides symbol processing; otherwise only valid symbols move the FSM.
   always_comb begin
      state_n    = state;
      cfg_lo_n   = cfg_lo;
      idle_cnt_n = idle_cnt;
      out_n      = lacr_out;
      stb_n      = 1'b0;
      err_inc    = 1'b0;
      if (los) begin
         state_n    = HUNT;
         idle_cnt_n = 4'd0;
      end else if (rx_valid) begin
         case (state)
            HUNT: begin
               if (rx_err) begin
                  err_inc    = 1'b1;
                  idle_cnt_n = 4'd0;
               end else if (is_comma) begin
                  state_n = COMMA;
               end
            end
            COMMA: begin
               if (rx_err) begin
                  err_inc    = 1'b1;
                  idle_cnt_n = 4'd0;
                  state_n    = HUNT;
               end else if (is_comma) begin
                  state_n = COMMA;
               end else if (is_cfg_id) begin
                  state_n = CFG_LO;
               end else if (is_idle_id) begin
                  if (idle_cnt != 4'd15)
                     idle_cnt_n = idle_cnt + 4'd1;
                  state_n = HUNT;
               end else begin
                  state_n = HUNT;
               end
            end
            CFG_LO, CFG_HI: begin
               // A K28.5 landing in a data slot is likely the next set, so resync on it.
               if (rx_err || rx_is_k) begin
                  err_inc    = 1'b1;
                  idle_cnt_n = 4'd0;
                  state_n    = (is_comma && !rx_err) ? COMMA : HUNT;
               end else if (state == CFG_LO) begin
                  cfg_lo_n = rx_data;
                  state_n  = CFG_HI;
               end else begin
                  out_n      = {rx_data, cfg_lo};
                  stb_n      = 1'b1;
                  idle_cnt_n = 4'd0;
                  state_n    = HUNT;
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state      <= HUNT;
         cfg_lo     <= 8'd0;
         idle_cnt   <= 4'd0;
         lacr_out   <= 16'd0;
         lacr_stb   <= 1'b0;
         idle_match <= 1'b0;
         err_cnt    <= 8'd0;
      end else begin
         state      <= state_n;
         cfg_lo     <= cfg_lo_n;
         idle_cnt   <= idle_cnt_n;
         lacr_out   <= out_n;
         lacr_stb   <= stb_n;
         idle_match <= (idle_cnt_n >= 4'(IDLE_COUNT));
         if (err_inc && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_lacr_rx.sv
// Directed bench for lacr_rx: config extraction, gaps, idle qualification,
// aborts, los, mid-set reset and error counter saturation.
module tb_lacr_rx;

   logic        rx_clk = 1'b0;
   logic        rst = 1'b0;
   logic        los = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_is_k = 1'b0;
   logic        rx_err = 1'b0;
   logic [15:0] lacr_out;
   logic        lacr_stb;
   logic        idle_match;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;
   int stb_seen = 0;

   lacr_rx #(.IDLE_COUNT(3)) dut (
      .rx_clk(rx_clk), .rst(rst), .los(los), .rx_valid(rx_valid),
      .rx_data(rx_data), .rx_is_k(rx_is_k), .rx_err(rx_err),
      .lacr_out(lacr_out), .lacr_stb(lacr_stb), .idle_match(idle_match),
      .err_cnt(err_cnt)
   );

   always #5 rx_clk = ~rx_clk;

   // One valid symbol per call; outputs are sampled 1ns after the edge that consumed it.
   task automatic apply_stimulus(input logic [7:0] d, input logic k, input logic e);
      rx_data = d; rx_is_k = k; rx_err = e; rx_valid = 1'b1;
      @(posedge rx_clk); #1;
      if (lacr_stb) stb_seen++;
   endtask

   task automatic gap(input int n);
      rx_valid = 1'b0; rx_is_k = 1'b0; rx_err = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge rx_clk); #1;
         if (lacr_stb) stb_seen++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; rx_valid = 1'b0; los = 1'b0;
      @(posedge rx_clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (lacr_out !== 16'h0 || lacr_stb !== 1'b0 || idle_match !== 1'b0 || err_cnt !== 8'h0) begin
         errors++;
         $display("[TB] FAIL reset: out=%h stb=%b idle=%b err=%h, expected 0000 0 0 00",
                  lacr_out, lacr_stb, idle_match, err_cnt);
      end
   endtask

   task automatic test_contiguous();
      apply_stimulus(8'hBC, 1, 0);
      apply_stimulus(8'hB5, 0, 0);
      apply_stimulus(8'h20, 0, 0);
      checks++;
      if (lacr_stb !== 1'b0) begin
         errors++; $display("[TB] FAIL contig_early_stb: stb=%b expected 0", lacr_stb);
      end
      apply_stimulus(8'h40, 0, 0);
      checks++;
      if (lacr_stb !== 1'b1 || lacr_out !== 16'h4020) begin
         errors++;
         $display("[TB] FAIL contig_strobe: stb=%b out=%h expected 1 4020", lacr_stb, lacr_out);
      end
      stb_seen = 0;
      gap(4);
      checks++;
      if (stb_seen !== 0 || lacr_out !== 16'h4020) begin
         errors++;
         $display("[TB] FAIL contig_hold: strobes=%0d out=%h expected 0 4020", stb_seen, lacr_out);
      end
   endtask

   task automatic test_gaps();
      stb_seen = 0;
      apply_stimulus(8'hBC, 1, 0); gap(2);
      apply_stimulus(8'h42, 0, 0); gap(2);
      apply_stimulus(8'hA0, 0, 0); gap(2);
      apply_stimulus(8'h41, 0, 0); gap(3);
      checks++;
      if (stb_seen !== 1 || lacr_out !== 16'h41A0) begin
         errors++;
         $display("[TB] FAIL gaps: strobes=%0d out=%h expected 1 41A0", stb_seen, lacr_out);
      end
   endtask

   task automatic test_idle();
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hC5, 0, 0);
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hC5, 0, 0);
      checks++;
      if (idle_match !== 1'b0) begin
         errors++; $display("[TB] FAIL idle_two_sets: idle=%b expected 0", idle_match);
      end
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hC5, 0, 0);
      checks++;
      if (idle_match !== 1'b1) begin
         errors++; $display("[TB] FAIL idle_three_sets: idle=%b expected 1", idle_match);
      end
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hB5, 0, 0);
      apply_stimulus(8'h00, 0, 0);
      checks++;
      if (idle_match !== 1'b1) begin
         errors++; $display("[TB] FAIL idle_held: idle=%b expected 1", idle_match);
      end
      apply_stimulus(8'h00, 0, 0);
      checks++;
      if (lacr_stb !== 1'b1 || lacr_out !== 16'h0000 || idle_match !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_cfg_clear: stb=%b out=%h idle=%b expected 1 0000 0",
                  lacr_stb, lacr_out, idle_match);
      end
   endtask

   task automatic test_abort();
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hB5, 0, 0);
      apply_stimulus(8'h20, 0, 0); apply_stimulus(8'h55, 0, 1);
      checks++;
      if (lacr_stb !== 1'b0 || err_cnt !== 8'd1 || lacr_out !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL abort_err: stb=%b err=%0d out=%h expected 0 1 0000",
                  lacr_stb, err_cnt, lacr_out);
      end
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hB5, 0, 0);
      apply_stimulus(8'h20, 0, 0); apply_stimulus(8'hBC, 1, 0);
      checks++;
      if (lacr_stb !== 1'b0 || err_cnt !== 8'd2) begin
         errors++;
         $display("[TB] FAIL abort_k: stb=%b err=%0d expected 0 2", lacr_stb, err_cnt);
      end
      apply_stimulus(8'hB5, 0, 0); apply_stimulus(8'h11, 0, 0);
      apply_stimulus(8'h22, 0, 0);
      checks++;
      if (lacr_stb !== 1'b1 || lacr_out !== 16'h2211) begin
         errors++;
         $display("[TB] FAIL abort_resync: stb=%b out=%h expected 1 2211", lacr_stb, lacr_out);
      end
   endtask

   task automatic test_los();
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'h50, 0, 0);
      end
      checks++;
      if (idle_match !== 1'b1) begin
         errors++; $display("[TB] FAIL los_pre_idle: idle=%b expected 1", idle_match);
      end
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hB5, 0, 0);
      apply_stimulus(8'h33, 0, 0);
      los = 1'b1;
      apply_stimulus(8'h44, 0, 0);
      checks++;
      if (lacr_stb !== 1'b0 || idle_match !== 1'b0 || lacr_out !== 16'h2211 || err_cnt !== 8'd2) begin
         errors++;
         $display("[TB] FAIL los_hi: stb=%b idle=%b out=%h err=%0d expected 0 0 2211 2",
                  lacr_stb, idle_match, lacr_out, err_cnt);
      end
      gap(2);
      los = 1'b0;
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hB5, 0, 0);
      apply_stimulus(8'h55, 0, 0); apply_stimulus(8'h66, 0, 0);
      checks++;
      if (lacr_stb !== 1'b1 || lacr_out !== 16'h6655) begin
         errors++;
         $display("[TB] FAIL los_recover: stb=%b out=%h expected 1 6655", lacr_stb, lacr_out);
      end
   endtask

   task automatic test_reset_mid();
      apply_stimulus(8'hBC, 1, 0); apply_stimulus(8'hB5, 0, 0);
      apply_stimulus(8'h77, 0, 0);
      rst = 1'b1;
      @(posedge rx_clk); #1;
      rst = 1'b0;
      checks++;
      if (lacr_out !== 16'h0 || lacr_stb !== 1'b0 || idle_match !== 1'b0 || err_cnt !== 8'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid: out=%h stb=%b idle=%b err=%h expected 0000 0 0 00",
                  lacr_out, lacr_stb, idle_match, err_cnt);
      end
      apply_stimulus(8'h88, 0, 0);
      gap(1);
      checks++;
      if (lacr_stb !== 1'b0 || lacr_out !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_leftover: stb=%b out=%h expected 0 0000", lacr_stb, lacr_out);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 254; i++) apply_stimulus(8'h00, 0, 1);
      checks++;
      if (err_cnt !== 8'd254) begin
         errors++; $display("[TB] FAIL sat_254: err=%0d expected 254", err_cnt);
      end
      for (int i = 0; i < 6; i++) apply_stimulus(8'h00, 0, 1);
      checks++;
      if (err_cnt !== 8'd255) begin
         errors++; $display("[TB] FAIL sat_255: err=%0d expected 255", err_cnt);
      end
      gap(1);
   endtask

   initial begin
      test_reset();
      test_contiguous();
      test_gaps();
      test_idle();
      test_abort();
      test_los();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
